// File: rtl/bsg_done_watchdog.sv
// Done watchdog: latches per-node done into a sticky mask, then drains or times out.
// Optional BSG_DONE_WATCHDOG_DISPLAY_EN adds simulation-only progress reporting.
module bsg_done_watchdog #(
  parameter int unsigned nodes_p          = 1,
  parameter int unsigned drain_cycles_p   = 5000,
  parameter int unsigned timeout_cycles_p = 1000000,
  parameter int unsigned ctr_width_p      = 32
) (
  input  logic                   clk_i,
  input  logic                   async_reset_n_i,
  input  logic                   en_i,
  input  logic [nodes_p-1:0]     done_i,
  output logic [nodes_p-1:0]     done_mask_o,
  output logic [ctr_width_p-1:0] cycle_ctr_o,
  output logic [2:0]             state_o,
  output logic                   finish_o,
  output logic                   timeout_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StDrain    = 3'd2,
    StFinished = 3'd3,
    StTimeout  = 3'd4
  } state_e;

  localparam logic [ctr_width_p-1:0] RunLast   = ctr_width_p'(timeout_cycles_p - 1);
  localparam logic [ctr_width_p-1:0] DrainLast = ctr_width_p'(drain_cycles_p - 1);

  state_e                 state_q, state_d;
  logic [nodes_p-1:0]     mask_q, mask_d;
  logic [ctr_width_p-1:0] run_q, run_d;
  logic [ctr_width_p-1:0] drain_q, drain_d;
  logic                   all_done;

  assign all_done = &(mask_q | done_i);

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q <= StIdle;
      mask_q  <= '0;
      run_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      drain_q <= drain_d;
    end
  end

  // all_done is checked before the budget so a last-edge finish still drains
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (en_i) state_d = StRun;
      end
      StRun: begin
        if (!en_i)                state_d = StIdle;
        else if (all_done)        state_d = StDrain;
        else if (run_q == RunLast) state_d = StTimeout;
      end
      StDrain: begin
        if (!en_i)                   state_d = StIdle;
        else if (drain_q == DrainLast) state_d = StFinished;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    mask_d  = mask_q;
    run_d   = run_q;
    drain_d = drain_q;
    if (state_q == StRun && en_i) begin
      mask_d = mask_q | done_i;
      // run count freezes on the edge that leaves RUN
      if (state_d == StRun) run_d = run_q + 1'b1;
    end
    if (state_q == StRun && state_d == StDrain) drain_d = '0;
    if (state_q == StDrain && state_d == StDrain) drain_d = drain_q + 1'b1;
    if (state_d == StIdle) begin
      mask_d  = '0;
      run_d   = '0;
      drain_d = '0;
    end
  end

  always_comb begin
    done_mask_o = mask_q;
    cycle_ctr_o = run_q;
    state_o     = state_q;
    finish_o    = (state_q == StFinished);
    timeout_o   = (state_q == StTimeout);
  end

`ifdef BSG_DONE_WATCHDOG_DISPLAY_EN
  logic finish_pending_q;

  always @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      finish_pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(nodes_p); i++) begin
        if (mask_d[i] && !mask_q[i]) $display("node %0d done at cycle %0d", i, run_q);
      end
      if (finish_pending_q) $finish;
      if (state_d == StFinished && state_q != StFinished) begin
        $display("finished");
        finish_pending_q <= 1'b1;
      end
      if (state_d == StTimeout && state_q != StTimeout) begin
        $display("TIMEOUT done_mask=%b", mask_d);
        $finish;
      end
    end
  end
`else
  // synthesizable build: no reporting logic
`endif

endmodule
